// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: counters, pixel request coordinates and pin-aligned RGB/HS/VS/BLANK_n.
// Optional build macro VGA_BORDER_EN forces a full-scale white border around the visible area.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_n,
  output logic       oFrame_Start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DEPTH   = PIPE_LAT + 2;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_BP   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_BP   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  generate
    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : gTotalCheck
      $error("vga_timing_ctrl: H_TOTAL/V_TOTAL must fit in 10-bit counters");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : gLatCheck
      $error("vga_timing_ctrl: PIPE_LAT must be 1..4");
    end
  endgenerate

  // Each porch/sync phase must be at least one clock (line) wide for the phase FSMs.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phaseT;

  logic [9:0] hCnt, hCntNext;
  logic [9:0] vCnt, vCntNext;
  logic       hWrap, vWrap;
  phaseT      hState, hStateNext;
  phaseT      vState, vStateNext;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hCnt   <= '0;
      vCnt   <= '0;
      hState <= PH_ACTIVE;
      vState <= PH_ACTIVE;
    end else begin
      hCnt   <= hCntNext;
      vCnt   <= vCntNext;
      hState <= hStateNext;
      vState <= vStateNext;
    end
  end

  always_comb begin
    hWrap      = (hCnt == H_LAST);
    vWrap      = (vCnt == V_LAST);
    hCntNext   = hWrap ? 10'd0 : hCnt + 10'd1;
    vCntNext   = vCnt;
    hStateNext = hState;
    vStateNext = vState;
    if (hWrap) begin
      vCntNext = vWrap ? 10'd0 : vCnt + 10'd1;
    end

    case (hState)
      PH_ACTIVE: if (hCntNext == H_FP)  hStateNext = PH_FRONT;
      PH_FRONT:  if (hCntNext == H_SY)  hStateNext = PH_SYNC;
      PH_SYNC:   if (hCntNext == H_BP)  hStateNext = PH_BACK;
      PH_BACK:   if (hCntNext == 10'd0) hStateNext = PH_ACTIVE;
      default:   hStateNext = PH_ACTIVE;
    endcase

    // Vertical phase only moves on a line wrap, so sync covers whole lines.
    if (hWrap) begin
      case (vState)
        PH_ACTIVE: if (vCntNext == V_FP)  vStateNext = PH_FRONT;
        PH_FRONT:  if (vCntNext == V_SY)  vStateNext = PH_SYNC;
        PH_SYNC:   if (vCntNext == V_BP)  vStateNext = PH_BACK;
        PH_BACK:   if (vCntNext == 10'd0) vStateNext = PH_ACTIVE;
        default:   vStateNext = PH_ACTIVE;
      endcase
    end
  end

  logic active0, hsRaw0, vsRaw0, frame0;

  always_comb begin
    active0 = (hState == PH_ACTIVE) && (vState == PH_ACTIVE);
    hsRaw0  = (hState != PH_SYNC);
    vsRaw0  = (vState != PH_SYNC);
    frame0  = (hCnt == 10'd0) && (vCnt == 10'd0);
  end

  // Index 0 is stage 1; index DEPTH-1 drives the pins.
  logic [DEPTH-1:0] actD, hsD, vsD, fsD;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      actD   <= '0;
      hsD    <= '1;
      vsD    <= '1;
      fsD    <= '0;
      oVGA_X <= '0;
      oVGA_Y <= '0;
    end else begin
      actD   <= {actD[DEPTH-2:0], active0};
      hsD    <= {hsD[DEPTH-2:0], hsRaw0};
      vsD    <= {vsD[DEPTH-2:0], vsRaw0};
      fsD    <= {fsD[DEPTH-2:0], frame0};
      oVGA_X <= active0 ? hCnt : 10'd0;
      oVGA_Y <= active0 ? vCnt : 10'd0;
    end
  end

`ifdef VGA_BORDER_EN
  localparam logic [9:0] H_EDGE = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_EDGE = 10'(V_ACTIVE - 1);

  logic             border0;
  logic [DEPTH-2:0] bordD;

  always_comb begin
    border0 = active0 && ((hCnt == 10'd0) || (hCnt == H_EDGE) ||
                          (vCnt == 10'd0) || (vCnt == V_EDGE));
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bordD <= '0;
    end else begin
      bordD <= {bordD[DEPTH-3:0], border0};
    end
  end
`endif

  // RGB register samples the source with the stage that lands on the pins next clock.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oVGA_R <= '0;
      oVGA_G <= '0;
      oVGA_B <= '0;
    end else if (actD[DEPTH-2]) begin
`ifdef VGA_BORDER_EN
      if (bordD[DEPTH-2]) begin
        oVGA_R <= 10'h3FF;
        oVGA_G <= 10'h3FF;
        oVGA_B <= 10'h3FF;
      end else begin
        oVGA_R <= iRed;
        oVGA_G <= iGreen;
        oVGA_B <= iBlue;
      end
`else
      oVGA_R <= iRed;
      oVGA_G <= iGreen;
      oVGA_B <= iBlue;
`endif
    end else begin
      oVGA_R <= '0;
      oVGA_G <= '0;
      oVGA_B <= '0;
    end
  end

  assign oVGA_BLANK_n = actD[DEPTH-1];
  assign oVGA_HS      = hsD[DEPTH-1];
  assign oVGA_VS      = vsD[DEPTH-1];
  assign oFrame_Start = fsD[DEPTH-1];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a shrunken raster; the source echoes X/Y back as red/green.
module tb_vga_timing_ctrl;
  localparam int HA = 40, HF = 4, HSW = 6, HB = 5;
  localparam int VA = 10, VF = 2, VSW = 2, VB = 3;
  localparam int PL = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int LAT = PL + 2;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n;
  logic [9:0] iRed, iGreen, iBlue;
  logic [9:0] oVGA_X, oVGA_Y, oVGA_R, oVGA_G, oVGA_B;
  logic       oVGA_HS, oVGA_VS, oVGA_BLANK_n, oFrame_Start;

  initial forever #5 iVGA_CLK = ~iVGA_CLK;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .PIPE_LAT(PL)
  ) dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oVGA_X(oVGA_X), .oVGA_Y(oVGA_Y),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS),
    .oVGA_BLANK_n(oVGA_BLANK_n), .oFrame_Start(oFrame_Start)
  );

  typedef struct packed {
    logic       blank, hs, vs, fs;
    logic [9:0] r, g, b, x, y;
  } expT;

  expT q[$];
  int  checks = 0, failures = 0;
  int  mh, mv, cyc, lastFs, blankRise, hsRun, vsRun, blankRun, fsCount;
  logic [9:0] xPrev, yPrev;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic expT resetEntry();
    expT e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  function automatic expT model(input int h, input int v);
    expT e;
    bit act, border;
    act    = (h < HA) && (v < VA);
    border = 1'b0;
`ifdef VGA_BORDER_EN
    border = act && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1);
`endif
    e.blank = act;
    e.hs    = !(h >= HA + HF && h < HA + HF + HSW);
    e.vs    = !(v >= VA + VF && v < VA + VF + VSW);
    e.fs    = (h == 0) && (v == 0);
    e.x     = act ? 10'(h) : 10'd0;
    e.y     = act ? 10'(v) : 10'd0;
    e.r     = !act ? 10'd0 : (border ? 10'h3FF : 10'(h));
    e.g     = !act ? 10'd0 : (border ? 10'h3FF : 10'(v));
    e.b     = act ? 10'h3FF : 10'd0;
    return e;
  endfunction

  task automatic comparePins(input string pfx, input expT e);
    checkVal({pfx, "_blank"}, 32'(oVGA_BLANK_n), 32'(e.blank));
    checkVal({pfx, "_hs"},    32'(oVGA_HS),      32'(e.hs));
    checkVal({pfx, "_vs"},    32'(oVGA_VS),      32'(e.vs));
    checkVal({pfx, "_fs"},    32'(oFrame_Start), 32'(e.fs));
    checkVal({pfx, "_r"},     32'(oVGA_R),       32'(e.r));
    checkVal({pfx, "_g"},     32'(oVGA_G),       32'(e.g));
    checkVal({pfx, "_b"},     32'(oVGA_B),       32'(e.b));
  endtask

  task automatic step(input bit doRelease, input bit doAssert);
    expT e;
    @(negedge iVGA_CLK);
    if (doAssert) begin
      iRST_n = 1'b0;
      #1;
    end
    if (doRelease) begin
      iRST_n = 1'b1;
      q.delete();
      repeat (LAT) q.push_back(resetEntry());
      mh = 0; mv = 0; cyc = 0; lastFs = -1; blankRise = -HT;
      hsRun = 0; vsRun = 0; blankRun = 0;
    end
    if (!iRST_n) begin
      e = resetEntry();
      comparePins("rst", e);
      checkVal("rst_x", 32'(oVGA_X), 32'(e.x));
      checkVal("rst_y", 32'(oVGA_Y), 32'(e.y));
    end else begin
      q.push_back(model(mh, mv));
      e = q.pop_front();
      comparePins("pix", e);
      checkVal("req_x", 32'(oVGA_X), 32'(q[LAT-2].x));
      checkVal("req_y", 32'(oVGA_Y), 32'(q[LAT-2].y));

      if (oFrame_Start) begin
        if (lastFs < 0) checkVal("fs_first", 32'(cyc), 32'(LAT));
        else checkVal("fs_period", 32'(cyc - lastFs), 32'(FT));
        lastFs = cyc;
        fsCount++;
      end
      if (oVGA_BLANK_n) begin
        if (blankRun == 0) blankRise = cyc;
        blankRun++;
      end else begin
        if (blankRun > 0) checkVal("blank_width", 32'(blankRun), 32'(HA));
        blankRun = 0;
      end
      if (!oVGA_HS) begin
        if (hsRun == 0 && cyc - blankRise < HT)
          checkVal("hs_offset", 32'(cyc - blankRise), 32'(HA + HF));
        hsRun++;
      end else begin
        if (hsRun > 0) checkVal("hs_width", 32'(hsRun), 32'(HSW));
        hsRun = 0;
      end
      if (!oVGA_VS) begin
        if (vsRun == 0 && lastFs >= 0)
          checkVal("vs_offset", 32'(cyc - lastFs), 32'((VA + VF) * HT));
        vsRun++;
      end else begin
        if (vsRun > 0) checkVal("vs_width", 32'(vsRun), 32'(VSW * HT));
        vsRun = 0;
      end

      cyc++;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    // Pixel source with one clock of latency from the request coordinates.
    iRed  = xPrev;
    iGreen = yPrev;
    iBlue = 10'h3FF;
    xPrev = oVGA_X;
    yPrev = oVGA_Y;
  endtask

  initial begin
    iRST_n = 1'b0;
    iRed = '0; iGreen = '0; iBlue = 10'h3FF;
    xPrev = '0; yPrev = '0;
    fsCount = 0;
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (2 * FT + 6 * HT + 20) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (2 * FT + 10) step(1'b0, 1'b0);
    checkVal("fs_count", 32'(fsCount), 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
